// File: rtl/pid_pwm_driver.sv
// -----------------------------------------------------------------------------
// pid_pwm_driver
//
// Purpose:
//   Output stage of the PID controller. It converts the signed Q-format PID
//   command into a sign-magnitude PWM drive for an actuator bridge:
//     - saturates the command magnitude to 1.0 (2^Q)
//     - scales the magnitude to a duty count in the range 0..PERIOD
//     - double-buffers duty/direction/saturation so they change only at the
//       PWM period boundary
//     - drives high/low gate outputs, a direction line and a sat flag
//
// Build option:
//   PID_PWM_DEADTIME_EN - when defined, dead-time insertion of DEADTIME cycles
//                         is compiled into the gate outputs. When undefined,
//                         pwm_h/pwm_l are the registered raw comparison and
//                         its complement, and DEADTIME has no effect.
//
// Parameters:
//   N        data width of the PID command
//   Q        fractional bits of the command (1.0 = 2^Q)
//   PERIOD   PWM period in clk cycles (2..2^CNT_W-1)
//   CNT_W    period counter width
//   DEADTIME dead-time cycles (< PERIOD/2), used only with the build option
//
// Ports:
//   clk           in   system clock
//   reset         in   asynchronous, active-low reset
//   data_in       in   signed Q(N-Q).Q PID command
//   data_valid    in   one-cycle strobe, data_in valid
//   pwm_h         out  high-side gate
//   pwm_l         out  low-side gate
//   dir           out  direction, 1 = negative command
//   sat           out  active command was clamped
//   period_start  out  one-cycle pulse while the counter is at 0
// -----------------------------------------------------------------------------
module pid_pwm_driver #(
   parameter int N        = 32,
   parameter int Q        = 18,
   parameter int PERIOD   = 1000,
   parameter int CNT_W    = 16,
   parameter int DEADTIME = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [N-1:0] data_in,
   input  logic         data_valid,
   output logic         pwm_h,
   output logic         pwm_l,
   output logic         dir,
   output logic         sat,
   output logic         period_start
);

   localparam logic [N:0]       ONE_FULL = (N+1)'(1) << Q;
   localparam logic [Q:0]       ONE_A    = (Q+1)'(1) << Q;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PERIOD - 1);
   localparam logic [2*N-1:0]   PERIOD_W = (2*N)'(PERIOD);

   // ------------------------------------------------------------------
   // Stage A: sign/magnitude split and clamp
   // ------------------------------------------------------------------
   logic [N:0] mag_full;
   logic       clamp;
   logic       dir_a_reg;
   logic       sat_a_reg;
   logic [Q:0] mag_a_reg;

   // Absolute value on N+1 bits so that the most negative input still
   // yields a correct positive magnitude.
   assign mag_full = data_in[N-1] ? ({1'b0, ~data_in} + (N+1)'(1))
                                  : {1'b0, data_in};
   assign clamp    = (mag_full >= ONE_FULL);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dir_a_reg <= 1'b0;
         sat_a_reg <= 1'b0;
         mag_a_reg <= '0;
      end else if (data_valid) begin
         dir_a_reg <= data_in[N-1];
         sat_a_reg <= clamp;
         mag_a_reg <= clamp ? ONE_A : mag_full[Q:0];
      end
   end

   // ------------------------------------------------------------------
   // Stage B: scale to duty count (shadow registers)
   // ------------------------------------------------------------------
   // Stage A only changes on a strobe, so copying it every cycle gives the
   // same result as loading one edge after each strobe.
   logic [2*N-1:0]   product;
   logic [CNT_W-1:0] shadow_duty_reg;
   logic             shadow_dir_reg;
   logic             shadow_sat_reg;
   logic             unused_bits;

   assign product = {{(2*N-Q-1){1'b0}}, mag_a_reg} * PERIOD_W;

   // mag_a <= 2^Q, so the scaled result never exceeds PERIOD and fits in
   // CNT_W bits; the remaining product bits are always zero or discarded
   // by the truncating shift.
   assign unused_bits = ^{product[2*N-1:Q+CNT_W], product[Q-1:0]};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         shadow_duty_reg <= '0;
         shadow_dir_reg  <= 1'b0;
         shadow_sat_reg  <= 1'b0;
      end else begin
         shadow_duty_reg <= product[Q +: CNT_W];
         shadow_dir_reg  <= dir_a_reg;
         shadow_sat_reg  <= sat_a_reg;
      end
   end

   // ------------------------------------------------------------------
   // Period counter and active (double-buffered) registers
   // ------------------------------------------------------------------
   logic [CNT_W-1:0] cnt_reg;
   logic [CNT_W-1:0] cnt_next;
   logic             wrap;
   logic [CNT_W-1:0] active_duty_reg;
   logic             active_dir_reg;
   logic             active_sat_reg;
   logic             raw;

   assign wrap     = (cnt_reg == LAST_CNT);
   assign cnt_next = wrap ? '0 : cnt_reg + CNT_W'(1);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_reg         <= '0;
         active_duty_reg <= '0;
         active_dir_reg  <= 1'b0;
         active_sat_reg  <= 1'b0;
      end else begin
         cnt_reg <= cnt_next;
         if (wrap) begin
            active_duty_reg <= shadow_duty_reg;
            active_dir_reg  <= shadow_dir_reg;
            active_sat_reg  <= shadow_sat_reg;
         end
      end
   end

   // Duty 0 never matches, duty PERIOD always matches (cnt <= PERIOD-1).
   assign raw = (cnt_reg < active_duty_reg);

   // ------------------------------------------------------------------
   // Output registers
   // ------------------------------------------------------------------
   logic period_start_reg;
   logic pwm_h_reg;
   logic pwm_l_reg;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         period_start_reg <= 1'b0;
      end else begin
         period_start_reg <= wrap;
      end
   end

`ifdef PID_PWM_DEADTIME_EN
   // Each gate has a down-counter that is reloaded while raw sits in the
   // opposite state. A gate asserts only once its counter has drained,
   // i.e. after DEADTIME consecutive cycles of raw in its own state, and
   // drops on the same edge raw leaves that state. The two gates can
   // therefore never be high together, and short raw pulses are swallowed.
   localparam logic [CNT_W-1:0] DT = CNT_W'(DEADTIME);
   logic [CNT_W-1:0] h_wait_reg;
   logic [CNT_W-1:0] l_wait_reg;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         h_wait_reg <= '0;
         l_wait_reg <= '0;
         pwm_h_reg  <= 1'b0;
         pwm_l_reg  <= 1'b0;
      end else if (raw) begin
         l_wait_reg <= DT;
         pwm_l_reg  <= 1'b0;
         if (h_wait_reg != '0) begin
            h_wait_reg <= h_wait_reg - CNT_W'(1);
            pwm_h_reg  <= 1'b0;
         end else begin
            pwm_h_reg  <= 1'b1;
         end
      end else begin
         h_wait_reg <= DT;
         pwm_h_reg  <= 1'b0;
         if (l_wait_reg != '0) begin
            l_wait_reg <= l_wait_reg - CNT_W'(1);
            pwm_l_reg  <= 1'b0;
         end else begin
            pwm_l_reg  <= 1'b1;
         end
      end
   end
`else
   logic unused_deadtime;
   assign unused_deadtime = (DEADTIME != 0);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pwm_h_reg <= 1'b0;
         pwm_l_reg <= 1'b0;
      end else begin
         pwm_h_reg <= raw;
         pwm_l_reg <= ~raw;
      end
   end
`endif

   assign pwm_h        = pwm_h_reg;
   assign pwm_l        = pwm_l_reg;
   assign dir          = active_dir_reg;
   assign sat          = active_sat_reg;
   assign period_start = period_start_reg;

endmodule

// File: tb/tb_pid_pwm_driver.sv
// -----------------------------------------------------------------------------
// tb_pid_pwm_driver
//
// Directed testbench for pid_pwm_driver with PERIOD=100, Q=18, N=32.
// Each period is walked cycle by cycle from a period_start cycle; the number
// of pwm_h / pwm_l high cycles, gate overlap, period_start cadence and the
// dir/sat flags are compared against hand-derived values.
// -----------------------------------------------------------------------------
module tb_pid_pwm_driver;

   localparam int N        = 32;
   localparam int Q        = 18;
   localparam int PERIOD   = 100;
   localparam int CNT_W    = 16;
   localparam int DEADTIME = 4;

   logic        clk        = 1'b0;
   logic        reset      = 1'b0;
   logic [31:0] data_in    = 32'd0;
   logic        data_valid = 1'b0;
   logic        pwm_h;
   logic        pwm_l;
   logic        dir;
   logic        sat;
   logic        period_start;

   int total     = 0;
   int bad       = 0;
   int prev_duty = 0;

   always #5 clk = ~clk;

   pid_pwm_driver #(
      .N        (N),
      .Q        (Q),
      .PERIOD   (PERIOD),
      .CNT_W    (CNT_W),
      .DEADTIME (DEADTIME)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .data_in      (data_in),
      .data_valid   (data_valid),
      .pwm_h        (pwm_h),
      .pwm_l        (pwm_l),
      .dir          (dir),
      .sat          (sat),
      .period_start (period_start)
   );

   // Expected high-side cycles in a period of duty d, given the previous
   // period's duty pd (only matters with dead time, where a high run that
   // started in the previous period carries over).
   function automatic int exp_hi(input int d, input int pd);
`ifdef PID_PWM_DEADTIME_EN
      if (d == 0) return 0;
      if (pd == PERIOD) return d;
      return (d > DEADTIME) ? d - DEADTIME : 0;
`else
      if (pd < 0) return -1;
      return d;
`endif
   endfunction

   function automatic int exp_lo(input int d, input int pd);
`ifdef PID_PWM_DEADTIME_EN
      int run;
      if (d == PERIOD) return 0;
      if (d == 0) begin
         if (pd == PERIOD) return PERIOD - DEADTIME;
         run = PERIOD - pd;
         return (run >= DEADTIME) ? PERIOD : PERIOD - (DEADTIME - run);
      end
      return (PERIOD - d > DEADTIME) ? PERIOD - d - DEADTIME : 0;
`else
      if (pd < 0) return -1;
      return PERIOD - d;
`endif
   endfunction

   // Step until period_start is seen (cycle with cnt == 0).
   task automatic wait_period_start(input string name);
      int n;
      n = 0;
      while (period_start !== 1'b1 && n < 3 * PERIOD) begin
         @(posedge clk);
         #1;
         n++;
      end
      total++;
      if (period_start !== 1'b1) begin
         bad++;
         $display("FAIL %s period_start: got %b want 1 within %0d cycles", name, period_start, 3 * PERIOD);
      end
   endtask

   // Must be entered in a cycle where cnt == 0 (period_start high). Walks one
   // full period, optionally strobing commands when the counter is at s1/s2,
   // and ends in the next period_start cycle. 'duty' is the active duty
   // expected for the walked period.
   task automatic run_period(input string name,
                             input int s1, input logic [31:0] v1,
                             input int s2, input logic [31:0] v2,
                             input int duty, input logic exp_dir, input logic exp_sat);
      int   hi;
      int   lo;
      int   both;
      int   ps_mid;
      logic ps_end;
      int   e_hi;
      int   e_lo;
      hi = 0; lo = 0; both = 0; ps_mid = 0; ps_end = 1'b0;
      e_hi = exp_hi(duty, prev_duty);
      e_lo = exp_lo(duty, prev_duty);

      total++;
      if (dir !== exp_dir) begin
         bad++;
         $display("FAIL %s dir: got %b want %b", name, dir, exp_dir);
      end
      total++;
      if (sat !== exp_sat) begin
         bad++;
         $display("FAIL %s sat: got %b want %b", name, sat, exp_sat);
      end

      for (int i = 0; i < PERIOD; i++) begin
         if (i == s1) begin
            data_in    = v1;
            data_valid = 1'b1;
         end else if (i == s2) begin
            data_in    = v2;
            data_valid = 1'b1;
         end else begin
            // junk on the bus without a strobe must not be taken
            data_in    = 32'h7FFF_0000 ^ 32'(i);
            data_valid = 1'b0;
         end
         @(posedge clk);
         #1;
         data_valid = 1'b0;
         if (pwm_h === 1'b1) hi++;
         if (pwm_l === 1'b1) lo++;
         if (pwm_h === 1'b1 && pwm_l === 1'b1) both++;
         if (i < PERIOD - 1 && period_start !== 1'b0) ps_mid++;
         if (i == PERIOD - 1) ps_end = period_start;
      end

      $display("period %s: duty=%0d hi=%0d lo=%0d dir=%b sat=%b", name, duty, hi, lo, exp_dir, exp_sat);

      total++;
      if (hi !== e_hi) begin
         bad++;
         $display("FAIL %s pwm_h cycles: got %0d want %0d", name, hi, e_hi);
      end
      total++;
      if (lo !== e_lo) begin
         bad++;
         $display("FAIL %s pwm_l cycles: got %0d want %0d", name, lo, e_lo);
      end
      total++;
      if (both !== 0) begin
         bad++;
         $display("FAIL %s gate overlap: got %0d cycles want 0", name, both);
      end
      total++;
      if (ps_mid !== 0 || ps_end !== 1'b1) begin
         bad++;
         $display("FAIL %s period_start cadence: got mid=%0d end=%b want mid=0 end=1", name, ps_mid, ps_end);
      end
      prev_duty = duty;
   endtask

   task automatic test_reset;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if ({pwm_h, pwm_l, dir, sat, period_start} !== 5'b00000) begin
         bad++;
         $display("FAIL reset outputs: got h=%b l=%b dir=%b sat=%b ps=%b want all 0",
                  pwm_h, pwm_l, dir, sat, period_start);
      end
      reset = 1'b1;
      @(posedge clk);
      #1;
      $display("reset released: pwm_h=%b pwm_l=%b", pwm_h, pwm_l);
      total++;
      if (pwm_l !== 1'b1 || pwm_h !== 1'b0) begin
         bad++;
         $display("FAIL reset first edge: got h=%b l=%b want h=0 l=1", pwm_h, pwm_l);
      end
      prev_duty = 0;
   endtask

   task automatic test_quarter;
      wait_period_start("quarter");
      run_period("quarter_load", 5, 32'h0001_0000, -1, 32'h0, 0, 1'b0, 1'b0);
      run_period("quarter", -1, 32'h0, -1, 32'h0, 25, 1'b0, 1'b0);
      run_period("quarter_hold", -1, 32'h0, -1, 32'h0, 25, 1'b0, 1'b0);
   endtask

   task automatic test_negative;
      run_period("neg_load", 5, 32'hFFFE_0000, -1, 32'h0, 25, 1'b0, 1'b0);
      run_period("neg_half", -1, 32'h0, -1, 32'h0, 50, 1'b1, 1'b0);
   endtask

   task automatic test_saturation;
      run_period("sat_pos_load", 5, 32'h000C_0000, -1, 32'h0, 50, 1'b1, 1'b0);
      run_period("sat_pos", -1, 32'h0, -1, 32'h0, 100, 1'b0, 1'b1);
      run_period("sat_min_load", 5, 32'h8000_0000, -1, 32'h0, 100, 1'b0, 1'b1);
      run_period("sat_min", -1, 32'h0, -1, 32'h0, 100, 1'b1, 1'b1);
      run_period("zero_load", 5, 32'h0000_0000, -1, 32'h0, 100, 1'b1, 1'b1);
      run_period("zero", -1, 32'h0, -1, 32'h0, 0, 1'b0, 1'b0);
   endtask

   task automatic test_double_buffer;
      run_period("db_setup", 5, 32'h0002_0000, -1, 32'h0, 0, 1'b0, 1'b0);
      // two strobes inside one period: current period keeps 50, last wins
      run_period("db_two_strobes", 10, 32'h0001_0000, 60, 32'h0003_0000, 50, 1'b0, 1'b0);
      // strobe at cnt 98 reaches the shadow only on the wrap edge itself
      run_period("db_late_strobe", 98, 32'h0001_0000, -1, 32'h0, 75, 1'b0, 1'b0);
      run_period("db_late_pending", -1, 32'h0, -1, 32'h0, 75, 1'b0, 1'b0);
      run_period("db_late_applied", -1, 32'h0, -1, 32'h0, 25, 1'b0, 1'b0);
   endtask

   task automatic test_reset_mid;
      run_period("rst_setup", 5, 32'hFFFE_0000, -1, 32'h0, 25, 1'b0, 1'b0);
      // now in cnt 0 of a period with duty 50, dir 1
      repeat (40) begin
         @(posedge clk);
         #1;
      end
      total++;
      if (pwm_h !== 1'b1 || dir !== 1'b1) begin
         bad++;
         $display("FAIL rst_mid before: got h=%b dir=%b want h=1 dir=1", pwm_h, dir);
      end
      reset = 1'b0;
      #1;
      $display("reset mid-period: h=%b l=%b dir=%b sat=%b ps=%b", pwm_h, pwm_l, dir, sat, period_start);
      total++;
      if ({pwm_h, pwm_l, dir, sat, period_start} !== 5'b00000) begin
         bad++;
         $display("FAIL rst_mid async clear: got h=%b l=%b dir=%b sat=%b ps=%b want all 0",
                  pwm_h, pwm_l, dir, sat, period_start);
      end
      repeat (2) @(posedge clk);
      #1;
      total++;
      if ({pwm_h, pwm_l, dir, sat, period_start} !== 5'b00000) begin
         bad++;
         $display("FAIL rst_mid held: got h=%b l=%b dir=%b sat=%b ps=%b want all 0",
                  pwm_h, pwm_l, dir, sat, period_start);
      end
      reset = 1'b1;
      @(posedge clk);
      #1;
      total++;
      if (pwm_l !== 1'b1 || pwm_h !== 1'b0) begin
         bad++;
         $display("FAIL rst_mid first edge: got h=%b l=%b want h=0 l=1", pwm_h, pwm_l);
      end
      prev_duty = 0;
      wait_period_start("rst_mid");
      run_period("rst_cleared", -1, 32'h0, -1, 32'h0, 0, 1'b0, 1'b0);
   endtask

   // 25 and 3 counts: with dead time the high side loses DEADTIME cycles per
   // pulse and a 3-cycle pulse vanishes; without it the counts are exact.
   task automatic test_dead_time;
      run_period("dt_q_load", 5, 32'h0001_0000, -1, 32'h0, 0, 1'b0, 1'b0);
      run_period("dt_quarter", -1, 32'h0, -1, 32'h0, 25, 1'b0, 1'b0);
      run_period("dt_small_load", 5, 32'h0000_1EB9, -1, 32'h0, 25, 1'b0, 1'b0);
      run_period("dt_small", -1, 32'h0, -1, 32'h0, 3, 1'b0, 1'b0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_quarter();
      test_negative();
      test_saturation();
      test_double_buffer();
      test_reset_mid();
      test_dead_time();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
